// File: rtl/altera_eth_pause_pkg.sv
// Shared types and constants for the pause-frame request generator.
//   pause_state_e : request FSM states
//   XOFF_BIT/XON_BIT : bit positions in the 2-bit pause control code
//   XON_QUANTA    : quanta carried by an XON (resume) frame
package altera_eth_pause_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_XOFF = 2'd1,
    PAUSED    = 2'd2,
    SEND_XON  = 2'd3
  } pause_state_e;

  localparam int          XOFF_BIT   = 1;
  localparam int          XON_BIT    = 0;
  localparam logic [15:0] XON_QUANTA = 16'h0000;

endpackage

// File: rtl/altera_eth_pause_refresh_timer.sv
// Loadable down-counter that times XOFF refreshes while the link is paused.
//   clk    : clock
//   reset  : synchronous active-high reset (count -> 0)
//   load_i : load REFRESH_CYCLES-1 (wins over enable)
//   en_i   : decrement by one, holding at zero
//   zero_o : count is zero
module altera_eth_pause_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 32'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int          W        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(REFRESH_CYCLES - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/altera_eth_pause_frame_req_gen.sv
// Turns the level-coded pause control from the FIFO adapter into handshaked
// pause-frame requests (XOFF with PAUSE_QUANTA, XON with zero quanta),
// refreshes XOFF periodically while paused, and counts accepted frames.
//   clk, reset           : clock, synchronous active-high reset
//   pause_ctrl_sink_data : [1] XOFF request, [0] XON request (level, no valid)
//   pause_req            : request valid, held until pause_ack
//   pause_quanta         : quanta of the current request
//   pause_ack            : MAC accept (transfer when pause_req & pause_ack)
//   paused               : high from XOFF acceptance to XON acceptance
//   xoff_count/xon_count : saturating accepted-frame counters
module altera_eth_pause_frame_req_gen
  import altera_eth_pause_pkg::*;
#(
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter int unsigned REFRESH_CYCLES = 32'd50000,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           pause_ctrl_sink_data,
  output logic                 pause_req,
  output logic [15:0]          pause_quanta,
  input  logic                 pause_ack,
  output logic                 paused,
  output logic [CNT_WIDTH-1:0] xoff_count,
  output logic [CNT_WIDTH-1:0] xon_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  pause_state_e         state_q, state_d;
  logic                 pause_req_q, pause_req_d;
  logic [15:0]          quanta_q, quanta_d;
  logic                 paused_q, paused_d;
  logic [CNT_WIDTH-1:0] xoff_cnt_q, xoff_cnt_d;
  logic [CNT_WIDTH-1:0] xon_cnt_q, xon_cnt_d;
  logic                 tmr_load, tmr_en, tmr_zero;
  logic                 accept;

  assign accept = pause_req_q & pause_ack;

  altera_eth_pause_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    paused_d   = paused_q;
    xoff_cnt_d = xoff_cnt_q;
    xon_cnt_d  = xon_cnt_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        // XON alone is meaningless here; XOFF wins when both are set.
        if (pause_ctrl_sink_data[XOFF_BIT]) state_d = SEND_XOFF;
      end
      SEND_XOFF: begin
        if (accept) begin
          state_d    = PAUSED;
          paused_d   = 1'b1;
          tmr_load   = 1'b1;
          xoff_cnt_d = (&xoff_cnt_q) ? xoff_cnt_q : xoff_cnt_q + CNT_ONE;
        end
      end
      PAUSED: begin
        // XON has priority over a refresh due in the same cycle.
        if (pause_ctrl_sink_data[XON_BIT]) state_d = SEND_XON;
        else if (tmr_zero)                 state_d = SEND_XOFF;
        else                               tmr_en  = 1'b1;
      end
      SEND_XON: begin
        if (accept) begin
          state_d   = IDLE;
          paused_d  = 1'b0;
          xon_cnt_d = (&xon_cnt_q) ? xon_cnt_q : xon_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request and quanta are decoded from the next state so both come out
    // of flops and stay frozen for as long as the state is held.
    pause_req_d = (state_d == SEND_XOFF) || (state_d == SEND_XON);
    case (state_d)
      SEND_XOFF: quanta_d = PAUSE_QUANTA;
      SEND_XON:  quanta_d = XON_QUANTA;
      default:   quanta_d = quanta_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pause_req_q <= 1'b0;
      quanta_q    <= '0;
      paused_q    <= 1'b0;
      xoff_cnt_q  <= '0;
      xon_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pause_req_q <= pause_req_d;
      quanta_q    <= quanta_d;
      paused_q    <= paused_d;
      xoff_cnt_q  <= xoff_cnt_d;
      xon_cnt_q   <= xon_cnt_d;
    end
  end

  assign pause_req    = pause_req_q;
  assign pause_quanta = quanta_q;
  assign paused       = paused_q;
  assign xoff_count   = xoff_cnt_q;
  assign xon_count    = xon_cnt_q;

endmodule

// File: tb/tb_altera_eth_pause_frame_req_gen.sv
module tb_altera_eth_pause_frame_req_gen;

  localparam int          R    = 8;
  localparam int          CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [15:0] Q    = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    pause_ctrl_sink_data;
  logic          pause_req;
  logic [15:0]   pause_quanta;
  logic          pause_ack;
  logic          paused;
  logic [CW-1:0] xoff_count;
  logic [CW-1:0] xon_count;

  altera_eth_pause_frame_req_gen #(
    .PAUSE_QUANTA  (Q),
    .REFRESH_CYCLES(R),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pause_ctrl_sink_data(pause_ctrl_sink_data),
    .pause_req           (pause_req),
    .pause_quanta        (pause_quanta),
    .pause_ack           (pause_ack),
    .paused              (paused),
    .xoff_count          (xoff_count),
    .xon_count           (xon_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding request (with its kind), the paused
  // flag, a countdown of cycles until refresh, and integer event totals.
  bit          m_req, m_is_xoff, m_paused;
  logic [15:0] m_q;
  int          m_timer, m_xoff, m_xon;

  task automatic model_edge(input logic [1:0] s, input logic a, input logic r);
    if (r) begin
      m_req = 0; m_is_xoff = 0; m_paused = 0; m_q = 16'h0;
      m_timer = 0; m_xoff = 0; m_xon = 0;
    end else if (m_req) begin
      if (a) begin
        m_req = 0;
        if (m_is_xoff) begin
          m_paused = 1;
          m_xoff   = (m_xoff < CMAX) ? m_xoff + 1 : CMAX;
          m_timer  = R - 1;
        end else begin
          m_paused = 0;
          m_xon    = (m_xon < CMAX) ? m_xon + 1 : CMAX;
        end
      end
    end else if (!m_paused) begin
      if (s[1]) begin m_req = 1; m_is_xoff = 1; m_q = Q; end
    end else if (s[0]) begin
      m_req = 1; m_is_xoff = 0; m_q = 16'h0;
    end else if (m_timer == 0) begin
      m_req = 1; m_is_xoff = 1; m_q = Q;
    end else begin
      m_timer = m_timer - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [1:0] s, input logic a, input logic r);
    pause_ctrl_sink_data = s;
    pause_ack            = a;
    reset                = r;
    @(posedge clk);
    model_edge(s, a, r);
    #1;
    chk({tag, ".req"},    32'(pause_req),    32'(m_req));
    chk({tag, ".quanta"}, 32'(pause_quanta), 32'(m_q));
    chk({tag, ".paused"}, 32'(paused),       32'(m_paused));
    chk({tag, ".xoff"},   32'(xoff_count),   32'(m_xoff));
    chk({tag, ".xon"},    32'(xon_count),    32'(m_xon));
  endtask

  initial begin
    int  last_rise;
    bit  prev_req;
    bit  found;
    int  req_cycles;

    pause_ctrl_sink_data = 2'b00;
    pause_ack            = 1'b0;
    reset                = 1'b1;

    // Reset state
    cyc("reset", 2'b00, 1'b0, 1'b1);
    cyc("reset", 2'b00, 1'b0, 1'b1);
    chk("reset.req_zero", 32'(pause_req), 32'd0);

    // Single XOFF pulse, ack on the third request cycle
    cyc("xoff1", 2'b10, 1'b0, 1'b0);
    req_cycles = int'(pause_req);
    cyc("xoff1", 2'b00, 1'b0, 1'b0);
    req_cycles += int'(pause_req);
    chk("xoff1.quanta_mid", 32'(pause_quanta), 32'hFFFF);
    cyc("xoff1", 2'b00, 1'b0, 1'b0);
    req_cycles += int'(pause_req);
    cyc("xoff1", 2'b00, 1'b1, 1'b0);
    chk("xoff1.req_cycles", 32'(req_cycles), 32'd3);
    chk("xoff1.paused", 32'(paused), 32'd1);
    chk("xoff1.count", 32'(xoff_count), 32'd1);

    // Held paused with immediate acks: refresh every R+1 cycles
    last_rise = -1;
    prev_req  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc("refresh", 2'b00, 1'b1, 1'b0);
      if (pause_req && !prev_req) begin
        chk("refresh.quanta", 32'(pause_quanta), 32'hFFFF);
        if (last_rise >= 0) chk("refresh.period", 32'(i - last_rise), 32'(R + 1));
        last_rise = i;
      end
      prev_req = pause_req;
    end

    // XON in the same cycle the refresh counter reaches zero
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_paused && !m_req && m_timer == 0) begin found = 1'b1; break; end
      cyc("to_zero", 2'b00, 1'b1, 1'b0);
    end
    chk("to_zero.found", 32'(found), 32'd1);
    cyc("xon_zero", 2'b01, 1'b0, 1'b0);
    chk("xon_zero.req", 32'(pause_req), 32'd1);
    chk("xon_zero.quanta", 32'(pause_quanta), 32'd0);
    cyc("xon_zero", 2'b00, 1'b1, 1'b0);
    chk("xon_zero.paused", 32'(paused), 32'd0);
    chk("xon_zero.xon", 32'(xon_count), 32'd1);

    // XOFF arriving during an unacknowledged XON does not abort it
    cyc("xon_hold", 2'b10, 1'b0, 1'b0);
    cyc("xon_hold", 2'b00, 1'b1, 1'b0);
    cyc("xon_hold", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("xon_hold", 2'b10, 1'b0, 1'b0);
      chk("xon_hold.quanta", 32'(pause_quanta), 32'd0);
    end
    cyc("xon_hold", 2'b10, 1'b1, 1'b0);
    chk("xon_hold.idle_req", 32'(pause_req), 32'd0);
    cyc("xon_hold", 2'b10, 1'b0, 1'b0);
    chk("xon_hold.next_xoff", 32'(pause_quanta), 32'hFFFF);

    // Reset in the middle of an XOFF handshake
    cyc("mid_rst", 2'b00, 1'b0, 1'b1);
    cyc("mid_rst", 2'b10, 1'b0, 1'b0);
    cyc("mid_rst", 2'b00, 1'b0, 1'b1);
    chk("mid_rst.req", 32'(pause_req), 32'd0);
    chk("mid_rst.xoff", 32'(xoff_count), 32'd0);
    cyc("mid_rst", 2'b00, 1'b0, 1'b0);

    // Counter saturation over many refreshes
    cyc("sat", 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) cyc("sat", 2'b00, 1'b1, 1'b0);
    chk("sat.xoff", 32'(xoff_count), 32'(CMAX));

    // Randomized traffic against the model
    cyc("rand", 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
